// File: rtl/l2_cache_update_queue_pkg.sv
`default_nettype none
// ============================================================================
// l2_cache_update_queue_pkg : shared L2 packet types and response-type mapping
// Rev 1.0
// ============================================================================
package l2_cache_update_queue_pkg;

  localparam int L2_WAYS          = 8;
  localparam int L2_SETS          = 256;
  localparam int CACHE_LINE_BYTES = 64;
  localparam int CORE_ID_WIDTH    = 4;
  localparam int THREAD_IDX_WIDTH = 2;
  localparam int L2_ADDR_WIDTH    = 26;

  typedef logic [CACHE_LINE_BYTES-1:0][7:0] cache_line_data_t;
  typedef logic [CACHE_LINE_BYTES-1:0]      cache_line_mask_t;

  typedef enum logic [3:0] {
    L2REQ_LOAD        = 4'd0,
    L2REQ_STORE       = 4'd1,
    L2REQ_LOAD_SYNC   = 4'd2,
    L2REQ_STORE_SYNC  = 4'd3,
    L2REQ_FLUSH       = 4'd4,
    L2REQ_IINVALIDATE = 4'd5,
    L2REQ_DINVALIDATE = 4'd6,
    L2REQ_LOCK        = 4'd7,
    L2REQ_UNLOCK      = 4'd8,
    L2REQ_PREFETCH    = 4'd9
  } l2req_packet_type_t;

  typedef enum logic [2:0] {
    L2RSP_LOAD_ACK        = 3'd0,
    L2RSP_STORE_ACK       = 3'd1,
    L2RSP_FLUSH_ACK       = 3'd2,
    L2RSP_IINVALIDATE_ACK = 3'd3,
    L2RSP_DINVALIDATE_ACK = 3'd4,
    L2RSP_LOCK_ACK        = 3'd5,
    L2RSP_UNLOCK_ACK      = 3'd6
  } l2rsp_packet_type_t;

  typedef enum logic {
    CT_DCACHE = 1'b0,
    CT_ICACHE = 1'b1
  } cache_type_t;

  typedef struct packed {
    logic [CORE_ID_WIDTH-1:0]    core;
    logic [THREAD_IDX_WIDTH-1:0] id;
    l2req_packet_type_t          packet_type;
    cache_type_t                 cache_type;
    logic [L2_ADDR_WIDTH-1:0]    address;
    cache_line_data_t            data;
    cache_line_mask_t            store_mask;
  } l2req_packet_t;

  typedef struct packed {
    logic                        status;
    logic [CORE_ID_WIDTH-1:0]    core;
    logic [THREAD_IDX_WIDTH-1:0] id;
    l2rsp_packet_type_t          packet_type;
    cache_type_t                 cache_type;
    logic [L2_ADDR_WIDTH-1:0]    address;
    cache_line_data_t            data;
  } l2rsp_packet_t;

  function automatic l2rsp_packet_type_t l2_rsp_type(input l2req_packet_type_t t);
    case (t)
      L2REQ_LOAD, L2REQ_LOAD_SYNC:   return L2RSP_LOAD_ACK;
      L2REQ_STORE, L2REQ_STORE_SYNC: return L2RSP_STORE_ACK;
      L2REQ_FLUSH:                   return L2RSP_FLUSH_ACK;
      L2REQ_IINVALIDATE:             return L2RSP_IINVALIDATE_ACK;
      L2REQ_DINVALIDATE:             return L2RSP_DINVALIDATE_ACK;
      L2REQ_LOCK:                    return L2RSP_LOCK_ACK;
      L2REQ_UNLOCK:                  return L2RSP_UNLOCK_ACK;
      default:                       return L2RSP_LOAD_ACK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_cache_update_queue_fifo.sv
`default_nettype none
// ============================================================================
// l2_response_fifo : generic synchronous FIFO, registered head, ready/valid pop
// Rev 1.0
// ============================================================================
module l2_response_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full_count = DEPTH[c_cnt_w-1:0];

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == c_full_count);
  assign o_valid   = !o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign w_pop_ok  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_cache_update_queue.sv
`default_nettype none
// ============================================================================
// l2_cache_update_queue : store merge, cache write port and response queue
// Rev 1.0
// ============================================================================
module l2_cache_update_queue
  import l2_cache_update_queue_pkg::*;
#(
  parameter int RSP_FIFO_DEPTH  = 4,
  parameter int STALL_SKID      = 2,
  parameter int CACHE_IDX_WIDTH = $clog2(L2_WAYS * L2_SETS),
  parameter int COUNTER_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       l2r_request_valid,
  input  l2req_packet_t              l2r_request,
  input  cache_line_data_t           l2r_data,
  input  logic                       l2r_cache_hit,
  input  logic [CACHE_IDX_WIDTH-1:0] l2r_hit_cache_idx,
  input  logic                       l2r_is_l2_fill,
  input  logic                       l2r_is_restarted_flush,
  input  cache_line_data_t           l2r_data_from_memory,
  input  logic                       l2r_store_sync_success,
  input  logic                       l2r_needs_writeback,
  output logic                       l2u_write_en,
  output logic [CACHE_IDX_WIDTH-1:0] l2u_write_addr,
  output cache_line_data_t           l2u_write_data,
  output logic                       l2u_stall,
  output logic                       l2_response_valid,
  input  logic                       l2_response_ready,
  output l2rsp_packet_t              l2_response,
  output logic                       l2u_overflow,
  output logic [COUNTER_WIDTH-1:0]   l2u_store_hit_count
);

  localparam int c_cnt_w = $clog2(RSP_FIFO_DEPTH) + 1;
  localparam logic [c_cnt_w-1:0] c_stall_level = c_cnt_w'(RSP_FIFO_DEPTH - STALL_SKID);

  l2req_packet_type_t       w_type;
  logic                     w_is_store;
  logic                     w_is_sync;
  logic                     w_update;
  logic                     w_completed_flush;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_push_ok;
  logic                     w_overflow;
  logic                     w_full;
  logic                     w_empty;
  logic [c_cnt_w-1:0]       w_count;
  logic [c_cnt_w-1:0]       w_next_count;
  cache_line_data_t         w_base;
  l2rsp_packet_t            w_rsp;
  logic                     r_stall;
  logic                     r_overflow;
  logic [COUNTER_WIDTH-1:0] r_store_hits;

  assign w_type     = l2r_request.packet_type;
  assign w_is_store = (w_type == L2REQ_STORE);
  assign w_is_sync  = (w_type == L2REQ_STORE_SYNC);
  assign w_update   = w_is_store || (w_is_sync && l2r_store_sync_success);

  always_comb begin
    w_base = l2r_is_l2_fill ? l2r_data_from_memory : l2r_data;
    for (int b = 0; b < CACHE_LINE_BYTES; b++) begin
      l2u_write_data[b] = (l2r_request.store_mask[b] && w_update) ? l2r_request.data[b] : w_base[b];
    end
  end

  assign l2u_write_en   = l2r_request_valid
                          && (l2r_is_l2_fill || (l2r_cache_hit && (w_is_store || w_is_sync)));
  assign l2u_write_addr = l2r_hit_cache_idx;

  // A flush only completes once no dirty data remains to be written back.
  assign w_completed_flush = (w_type == L2REQ_FLUSH)
                             && (l2r_is_restarted_flush || !l2r_cache_hit || !l2r_needs_writeback);
  assign w_push = l2r_request_valid
                  && ((l2r_cache_hit && (w_type != L2REQ_FLUSH)) || l2r_is_l2_fill || w_completed_flush
                      || (w_type == L2REQ_DINVALIDATE) || (w_type == L2REQ_IINVALIDATE));

  always_comb begin
    w_rsp             = '0;
    w_rsp.status      = w_is_sync ? l2r_store_sync_success : 1'b1;
    w_rsp.core        = l2r_request.core;
    w_rsp.id          = l2r_request.id;
    w_rsp.packet_type = l2_rsp_type(w_type);
    w_rsp.cache_type  = l2r_request.cache_type;
    w_rsp.address     = l2r_request.address;
    w_rsp.data        = l2u_write_data;
  end

  assign w_pop        = l2_response_valid && l2_response_ready;
  assign w_push_ok    = w_push && (!w_full || w_pop);
  assign w_overflow   = w_push && w_full && !w_pop;
  assign w_next_count = w_count + c_cnt_w'(w_push_ok) - c_cnt_w'(w_pop);

  l2_response_fifo #(
    .WIDTH ($bits(l2rsp_packet_t)),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_rsp),
    .i_pop   (w_pop),
    .o_valid (l2_response_valid),
    .o_data  (l2_response),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall      <= 1'b0;
      r_overflow   <= 1'b0;
      r_store_hits <= '0;
    end else begin
      r_stall <= (w_next_count >= c_stall_level);
      if (w_overflow) r_overflow <= 1'b1;
      if (l2u_write_en && !l2r_is_l2_fill && w_update) r_store_hits <= r_store_hits + COUNTER_WIDTH'(1);
    end
  end

  assign l2u_stall           = r_stall;
  assign l2u_overflow        = r_overflow;
  assign l2u_store_hit_count = r_store_hits;

  a_rsp_dropped: assert property (@(posedge clk) disable iff (!reset) !w_overflow)
    else $warning("l2_cache_update_queue: response dropped on full queue");
  a_restart_is_flush: assert property (@(posedge clk) disable iff (!reset)
    (l2r_request_valid && l2r_is_restarted_flush) |-> (w_type == L2REQ_FLUSH));
  a_restart_not_fill: assert property (@(posedge clk) disable iff (!reset)
    !(l2r_request_valid && l2r_is_restarted_flush && l2r_is_l2_fill));
  a_pop_nonempty: assert property (@(posedge clk) disable iff (!reset) w_pop |-> !w_empty);

endmodule
`default_nettype wire

// File: tb/tb_l2_cache_update_queue.sv
`default_nettype none
// Bench for l2_cache_update_queue: vector table plus queue corner-case sequences.
module tb_l2_cache_update_queue;
  import l2_cache_update_queue_pkg::*;

  localparam int IDX_W = $clog2(L2_WAYS * L2_SETS);
  localparam logic [7:0] ST_B  = 8'hAA;
  localparam logic [7:0] MEM_B = 8'h5C;
  localparam int NV = 19;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 l2r_request_valid;
  l2req_packet_t        l2r_request;
  cache_line_data_t     l2r_data;
  logic                 l2r_cache_hit;
  logic [IDX_W-1:0]     l2r_hit_cache_idx;
  logic                 l2r_is_l2_fill;
  logic                 l2r_is_restarted_flush;
  cache_line_data_t     l2r_data_from_memory;
  logic                 l2r_store_sync_success;
  logic                 l2r_needs_writeback;
  logic                 l2u_write_en;
  logic [IDX_W-1:0]     l2u_write_addr;
  cache_line_data_t     l2u_write_data;
  logic                 l2u_stall;
  logic                 l2_response_valid;
  logic                 l2_response_ready;
  l2rsp_packet_t        l2_response;
  logic                 l2u_overflow;
  logic [31:0]          l2u_store_hit_count;

  always #5 clk = ~clk;

  l2_cache_update_queue #(
    .RSP_FIFO_DEPTH  (4),
    .STALL_SKID      (2),
    .CACHE_IDX_WIDTH (IDX_W),
    .COUNTER_WIDTH   (32)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .l2r_request_valid      (l2r_request_valid),
    .l2r_request            (l2r_request),
    .l2r_data               (l2r_data),
    .l2r_cache_hit          (l2r_cache_hit),
    .l2r_hit_cache_idx      (l2r_hit_cache_idx),
    .l2r_is_l2_fill         (l2r_is_l2_fill),
    .l2r_is_restarted_flush (l2r_is_restarted_flush),
    .l2r_data_from_memory   (l2r_data_from_memory),
    .l2r_store_sync_success (l2r_store_sync_success),
    .l2r_needs_writeback    (l2r_needs_writeback),
    .l2u_write_en           (l2u_write_en),
    .l2u_write_addr         (l2u_write_addr),
    .l2u_write_data         (l2u_write_data),
    .l2u_stall              (l2u_stall),
    .l2_response_valid      (l2_response_valid),
    .l2_response_ready      (l2_response_ready),
    .l2_response            (l2_response),
    .l2u_overflow           (l2u_overflow),
    .l2u_store_hit_count    (l2u_store_hit_count)
  );

  typedef struct {
    l2req_packet_type_t t;
    logic hit, fill, rest, sync_ok, wb;
    cache_line_mask_t mask;
    logic [7:0] line_b;
    logic exp_we, exp_push, exp_merge, exp_status, exp_inc;
    l2rsp_packet_type_t exp_rsp;
  } vec_t;

  vec_t          vecs [NV];
  l2rsp_packet_t exp_q [$];
  l2rsp_packet_t mon_e;
  int            total = 0;
  int            bad = 0;
  int            exp_cnt = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input l2req_packet_type_t t, input logic hit, input logic fill,
                              input logic rest, input logic sync_ok, input logic wb,
                              input cache_line_mask_t mask, input logic [7:0] lb,
                              input logic we, input logic push, input logic merge,
                              input logic st, input logic inc, input l2rsp_packet_type_t r);
    vec_t v;
    v.t = t; v.hit = hit; v.fill = fill; v.rest = rest; v.sync_ok = sync_ok; v.wb = wb;
    v.mask = mask; v.line_b = lb; v.exp_we = we; v.exp_push = push; v.exp_merge = merge;
    v.exp_status = st; v.exp_inc = inc; v.exp_rsp = r;
    return v;
  endfunction

  function automatic logic [L2_ADDR_WIDTH-1:0] addr_of(input int k);
    return L2_ADDR_WIDTH'(32'h100 + k * 64);
  endfunction

  function automatic cache_line_data_t model_line(input cache_line_mask_t mask, input logic merge,
                                                  input logic fill, input logic [7:0] line_b);
    cache_line_data_t d;
    for (int b = 0; b < CACHE_LINE_BYTES; b++)
      d[b] = (mask[b] && merge) ? ST_B : (fill ? MEM_B : line_b);
    return d;
  endfunction

  function automatic l2rsp_packet_t exp_rsp(input l2rsp_packet_type_t t, input logic st,
                                            input int k, input cache_line_data_t d);
    l2rsp_packet_t r;
    r.status = st;
    r.core = CORE_ID_WIDTH'(k);
    r.id = THREAD_IDX_WIDTH'(k);
    r.packet_type = t;
    r.cache_type = cache_type_t'(k[0]);
    r.address = addr_of(k);
    r.data = d;
    return r;
  endfunction

  task automatic drive_idle();
    l2r_request_valid = 1'b0;
    l2r_request = '0;
    l2r_data = '0;
    l2r_data_from_memory = '0;
    l2r_cache_hit = 1'b0;
    l2r_hit_cache_idx = '0;
    l2r_is_l2_fill = 1'b0;
    l2r_is_restarted_flush = 1'b0;
    l2r_store_sync_success = 1'b0;
    l2r_needs_writeback = 1'b0;
  endtask

  task automatic drive_req(input l2req_packet_type_t t, input logic hit, input logic fill,
                           input logic rest, input logic sync_ok, input logic wb,
                           input cache_line_mask_t mask, input logic [7:0] line_b, input int k);
    l2r_request_valid = 1'b1;
    l2r_request.packet_type = t;
    l2r_request.core = CORE_ID_WIDTH'(k);
    l2r_request.id = THREAD_IDX_WIDTH'(k);
    l2r_request.cache_type = cache_type_t'(k[0]);
    l2r_request.address = addr_of(k);
    l2r_request.store_mask = mask;
    for (int b = 0; b < CACHE_LINE_BYTES; b++) begin
      l2r_request.data[b] = ST_B;
      l2r_data[b] = line_b;
      l2r_data_from_memory[b] = MEM_B;
    end
    l2r_cache_hit = hit;
    l2r_is_l2_fill = fill;
    l2r_is_restarted_flush = rest;
    l2r_store_sync_success = sync_ok;
    l2r_needs_writeback = wb;
    l2r_hit_cache_idx = IDX_W'(k * 3 + 7);
  endtask

  task automatic push_load(input int k);
    drive_req(L2REQ_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'(k), k);
    exp_q.push_back(exp_rsp(L2RSP_LOAD_ACK, 1'b1, k, model_line('0, 1'b0, 1'b0, 8'(k))));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    l2_response_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #2;
    check({name, "_left"}, 512'(exp_q.size()), 512'd0);
    check({name, "_valid"}, l2_response_valid, 1'b0);
  endtask

  // Scoreboard: every handshake pops and compares the oldest expected response.
  always @(negedge clk) begin
    if (reset && l2_response_valid && l2_response_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1'b1, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_type", l2_response.packet_type, mon_e.packet_type);
        check("rsp_status", l2_response.status, mon_e.status);
        check("rsp_core_id", {l2_response.core, l2_response.id, l2_response.cache_type},
              {mon_e.core, mon_e.id, mon_e.cache_type});
        check("rsp_address", l2_response.address, mon_e.address);
        check("rsp_data", l2_response.data, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = mk(L2REQ_STORE_SYNC, 1, 0, 0, 0, 0, '1,            8'h33, 1, 1, 0, 0, 0, L2RSP_STORE_ACK);
    vecs[1]  = mk(L2REQ_STORE,      1, 0, 0, 0, 0, 64'hF,         8'h00, 1, 1, 1, 1, 1, L2RSP_STORE_ACK);
    vecs[2]  = mk(L2REQ_STORE_SYNC, 1, 0, 0, 1, 0, 64'hF0,        8'h11, 1, 1, 1, 1, 1, L2RSP_STORE_ACK);
    vecs[3]  = mk(L2REQ_LOAD,       1, 0, 0, 0, 0, '0,            8'h22, 0, 1, 0, 1, 0, L2RSP_LOAD_ACK);
    vecs[4]  = mk(L2REQ_LOAD,       0, 0, 0, 0, 0, '0,            8'h23, 0, 0, 0, 1, 0, L2RSP_LOAD_ACK);
    vecs[5]  = mk(L2REQ_LOAD,       0, 1, 0, 0, 0, '0,            8'h24, 1, 1, 0, 1, 0, L2RSP_LOAD_ACK);
    vecs[6]  = mk(L2REQ_STORE,      0, 1, 0, 0, 0, 64'hFF00,      8'h25, 1, 1, 1, 1, 0, L2RSP_STORE_ACK);
    vecs[7]  = mk(L2REQ_FLUSH,      1, 0, 0, 0, 1, '0,            8'h26, 0, 0, 0, 1, 0, L2RSP_FLUSH_ACK);
    vecs[8]  = mk(L2REQ_FLUSH,      1, 0, 1, 0, 1, '0,            8'h27, 0, 1, 0, 1, 0, L2RSP_FLUSH_ACK);
    vecs[9]  = mk(L2REQ_FLUSH,      0, 0, 0, 0, 1, '0,            8'h28, 0, 1, 0, 1, 0, L2RSP_FLUSH_ACK);
    vecs[10] = mk(L2REQ_FLUSH,      1, 0, 0, 0, 0, '0,            8'h29, 0, 1, 0, 1, 0, L2RSP_FLUSH_ACK);
    vecs[11] = mk(L2REQ_DINVALIDATE,0, 0, 0, 0, 0, '0,            8'h2A, 0, 1, 0, 1, 0, L2RSP_DINVALIDATE_ACK);
    vecs[12] = mk(L2REQ_IINVALIDATE,0, 0, 0, 0, 0, '0,            8'h2B, 0, 1, 0, 1, 0, L2RSP_IINVALIDATE_ACK);
    vecs[13] = mk(L2REQ_LOCK,       1, 0, 0, 0, 0, '0,            8'h2C, 0, 1, 0, 1, 0, L2RSP_LOCK_ACK);
    vecs[14] = mk(L2REQ_UNLOCK,     1, 0, 0, 0, 0, '0,            8'h2D, 0, 1, 0, 1, 0, L2RSP_UNLOCK_ACK);
    vecs[15] = mk(L2REQ_STORE,      0, 0, 0, 0, 0, 64'h3,         8'h2E, 0, 0, 1, 1, 0, L2RSP_STORE_ACK);
    vecs[16] = mk(L2REQ_LOAD_SYNC,  1, 0, 0, 0, 0, '0,            8'h2F, 0, 1, 0, 1, 0, L2RSP_LOAD_ACK);
    vecs[17] = mk(L2REQ_PREFETCH,   1, 0, 0, 0, 0, '0,            8'h30, 0, 1, 0, 1, 0, L2RSP_LOAD_ACK);
    vecs[18] = mk(L2REQ_STORE_SYNC, 0, 0, 0, 1, 0, 64'hF,         8'h31, 0, 0, 1, 1, 0, L2RSP_STORE_ACK);

    drive_idle();
    l2_response_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("reset_valid", l2_response_valid, 1'b0);
    check("reset_stall", l2u_stall, 1'b0);
    check("reset_overflow", l2u_overflow, 1'b0);
    check("reset_counter", l2u_store_hit_count, 32'd0);
    reset = 1'b1;

    // Table: one request per cycle, responses drained continuously.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #2;
      drive_req(vecs[i].t, vecs[i].hit, vecs[i].fill, vecs[i].rest, vecs[i].sync_ok,
                vecs[i].wb, vecs[i].mask, vecs[i].line_b, i);
      #1;
      check("counter", l2u_store_hit_count, 32'(exp_cnt));
      check("write_en", l2u_write_en, vecs[i].exp_we);
      check("write_addr", l2u_write_addr, IDX_W'(i * 3 + 7));
      check("write_data", l2u_write_data,
            model_line(vecs[i].mask, vecs[i].exp_merge, vecs[i].fill, vecs[i].line_b));
      if (vecs[i].exp_push)
        exp_q.push_back(exp_rsp(vecs[i].exp_rsp, vecs[i].exp_status, i,
                                model_line(vecs[i].mask, vecs[i].exp_merge, vecs[i].fill, vecs[i].line_b)));
      if (vecs[i].exp_inc) exp_cnt++;
    end
    @(posedge clk);
    #2;
    drive_idle();
    #1;
    check("counter_table", l2u_store_hit_count, 32'(exp_cnt));
    drain("table_drain");

    // Full queue with simultaneous pop and push; 8 entries wrap the pointers.
    reset = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    l2_response_ready = 1'b0;
    for (int k = 20; k < 24; k++) begin
      @(posedge clk);
      #2;
      push_load(k);
    end
    for (int k = 24; k < 28; k++) begin
      @(posedge clk);
      #2;
      l2_response_ready = 1'b1;
      push_load(k);
      #1;
      check("full_count", dut.u_rsp_fifo.o_count, 3'd4);
      check("full_no_overflow", l2u_overflow, 1'b0);
    end
    @(posedge clk);
    #2;
    drive_idle();
    l2_response_ready = 1'b0;
    #1;
    check("full_pop_push_count", dut.u_rsp_fifo.o_count, 3'd4);
    check("full_pop_push_overflow", l2u_overflow, 1'b0);
    drain("wrap_drain");

    // Backpressure: stall threshold, stable head, overflow on fifth push.
    l2_response_ready = 1'b0;
    @(posedge clk);
    #2;
    push_load(40);
    @(posedge clk);
    #2;
    push_load(41);
    #1;
    check("stall_after_1", l2u_stall, 1'b0);
    @(posedge clk);
    #2;
    push_load(42);
    #1;
    check("stall_after_2", l2u_stall, 1'b1);
    @(posedge clk);
    #2;
    push_load(43);
    #1;
    check("count_3", dut.u_rsp_fifo.o_count, 3'd3);
    check("head_hold_3", l2_response.address, addr_of(40));
    check("head_valid", l2_response_valid, 1'b1);
    @(posedge clk);
    #2;
    drive_req(L2REQ_STORE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h1, 8'h77, 44);
    #1;
    check("count_4", dut.u_rsp_fifo.o_count, 3'd4);
    check("drop_write_en", l2u_write_en, 1'b1);
    check("pre_drop_overflow", l2u_overflow, 1'b0);
    exp_cnt++;
    @(posedge clk);
    #2;
    drive_idle();
    #1;
    check("drop_overflow", l2u_overflow, 1'b1);
    check("drop_count", dut.u_rsp_fifo.o_count, 3'd4);
    check("drop_head", l2_response.address, addr_of(40));
    check("drop_counter", l2u_store_hit_count, 32'(exp_cnt));
    check("drop_stall", l2u_stall, 1'b1);
    l2_response_ready = 1'b1;
    @(posedge clk);
    #2;
    l2_response_ready = 1'b0;
    #1;
    check("after_pop_count", dut.u_rsp_fifo.o_count, 3'd3);
    check("overflow_sticky", l2u_overflow, 1'b1);

    // Asynchronous reset with three entries queued.
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_reset_valid", l2_response_valid, 1'b0);
    check("mid_reset_stall", l2u_stall, 1'b0);
    check("mid_reset_overflow", l2u_overflow, 1'b0);
    check("mid_reset_counter", l2u_store_hit_count, 32'd0);
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    l2_response_ready = 1'b1;
    push_load(60);
    #1;
    check("post_reset_no_bypass", l2_response_valid, 1'b0);
    @(posedge clk);
    #2;
    drive_idle();
    #1;
    check("post_reset_visible", l2_response_valid, 1'b1);
    check("post_reset_head", l2_response.address, addr_of(60));
    drain("reset_drain");
    check("final_counter", l2u_store_hit_count, 32'(exp_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_cache_update_queue.md
Name: l2_cache_update_queue

Overview:
Next-generation L2 update stage, placed between l2_cache_read_stage and the core response interconnect. It merges store data into the line (byte mask) and drives the cache write port. It also queues responses in a parametrised FIFO with ready/valid backpressure toward the interconnect and a stall signal toward the upstream pipeline. It keeps a sticky overflow flag and a store-hit event counter.

Parameters:
RSP_FIFO_DEPTH, 4, response FIFO entries; power of two, >= 4.
STALL_SKID, 2, free entries reserved for requests already in flight above this stage; must be < RSP_FIFO_DEPTH.
CACHE_IDX_WIDTH, $clog2(`L2_WAYS * `L2_SETS), cache line index width.
COUNTER_WIDTH, 32, width of the event counter.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
l2r_request_valid  in  1  request present from read stage
l2r_request  in  l2req_packet_t  request packet
l2r_data  in  cache_line_data_t  line read from cache
l2r_cache_hit  in  1  tag hit
l2r_hit_cache_idx  in  CACHE_IDX_WIDTH  line index (hit or fill victim)
l2r_is_l2_fill  in  1  request carries memory fill data
l2r_is_restarted_flush  in  1  second pass of a flush
l2r_data_from_memory  in  cache_line_data_t  fill data
l2r_store_sync_success  in  1  store-sync reservation valid
l2r_needs_writeback  in  1  line dirty
l2u_write_en  out  1  cache data write strobe (combinational)
l2u_write_addr  out  CACHE_IDX_WIDTH  write index (combinational)
l2u_write_data  out  cache_line_data_t  merged line (combinational)
l2u_stall  out  1  upstream must stop issuing new requests
l2_response_valid  out  1  FIFO head valid
l2_response_ready  in  1  interconnect accepts head
l2_response  out  l2rsp_packet_t  FIFO head packet
l2u_overflow  out  1  sticky: a push was dropped
l2u_store_hit_count  out  COUNTER_WIDTH  count of committed store writes

Behaviour:
- Reset (reset==0, async): FIFO empty, l2_response_valid=0, l2u_stall=0, l2u_overflow=0, counter=0. l2_response contents are don't-care. An in-flight FIFO is discarded.
- Merge: base = l2r_is_l2_fill ? l2r_data_from_memory : l2r_data.
  - update = (type==STORE) || (type==STORE_SYNC && l2r_store_sync_success).
  - Per byte b: write_data[b] = (store_mask[b] && update) ? request.data[b] : base[b].
- l2u_write_en = valid && (fill || (hit && type in {STORE, STORE_SYNC})). Never gated by FIFO state.
- l2u_write_addr = l2r_hit_cache_idx.
- Push condition: valid && ((hit && type!=FLUSH) || fill || completed_flush || type in {DINVALIDATE, IINVALIDATE}).
  - completed_flush = type==FLUSH && (restarted_flush || !hit || !needs_writeback).
- Pushed entry fields:
  - status = STORE_SYNC ? sync_success : 1.
  - core, id, cache_type, address copied from the request.
  - data = l2u_write_data.
  - packet_type mapping: LOAD/LOAD_SYNC->LOAD_ACK; STORE/STORE_SYNC->STORE_ACK; FLUSH->FLUSH_ACK; IINVALIDATE->IINVALIDATE_ACK; DINVALIDATE->DINVALIDATE_ACK; LOCK->LOCK_ACK; UNLOCK->UNLOCK_ACK; other->LOAD_ACK.
- Latency: a push in cycle N makes the entry visible at the head no earlier than cycle N+1 (registered). There is no combinational bypass.
- Pop: occurs on a cycle with l2_response_valid && l2_response_ready. l2_response is held stable while valid && !ready.
- Occupancy count, width $clog2(RSP_FIFO_DEPTH)+1:
  - push only: +1; pop only: -1; push and pop together: unchanged.
  - Pointers wrap modulo RSP_FIFO_DEPTH.
- Full with a simultaneous pop: the push is accepted.
- Full with no pop: the push is dropped, l2u_overflow is set (sticky until reset), and an assertion fires. The cache write still occurs.
- l2u_stall is registered: l2u_stall = (next_count >= RSP_FIFO_DEPTH - STALL_SKID).
- Empty: l2_response_valid=0. A pop attempt while empty is impossible by construction.
- Counter: increments on l2u_write_en && !fill && update. It wraps at 2^COUNTER_WIDTH.
- Assertions:
  - restarted_flush implies type==FLUSH.
  - restarted_flush and fill are never both set.

Decomposition:
- Existing package (defines.sv) keeps l2req_packet_t, l2rsp_packet_t, cache_line_data_t, and the L2 packet enums.
- Add there a function l2_rsp_type(l2req_packet_type_t) returning l2rsp_packet_type_t, so the mapping can be reused.
- One sub-module: l2_response_fifo. It is a generic synchronous FIFO parametrised by WIDTH/DEPTH, with ready/valid output, count, and full/empty flags. It is instantiated with WIDTH=$bits(l2rsp_packet_t).

Test Plan:
- Store hit, mask=0x...000F, data bytes 0..3=0xAA, line all 0x00:
  - write_en=1 and write_data bytes 0..3=0xAA, rest 0x00.
  - One cycle later: response STORE_ACK, status=1, counter=1.
- STORE_SYNC hit with sync_success=0, mask all ones:
  - write_en=1 and write_data equals l2r_data.
  - Response status=0; counter stays 0.
- DEPTH=4, SKID=2, ready held 0, three load hits:
  - l2u_stall=1 after the 2nd push.
  - Count=3; head stays the first packet, unchanged.
- Fill FIFO to 4 with ready=0, then push a 5th:
  - l2u_overflow=1 and count stays 4.
  - Cache write_en still 1 for the 5th.
- Full FIFO with ready=1 and a push in the same cycle:
  - Count stays 4, no overflow.
  - Drain order matches push order across a pointer wrap (8 pushes total).
- Assert reset (0) mid-stream with 3 entries queued:
  - Immediately valid=0, stall=0, overflow=0, counter=0.
  - After release, first new push appears one cycle later.
